// File: rtl/skinny_subcells_dom1_sched.sv
// Walks the 16 cells of a two-share SKINNY-128 state through one shared DOM S-box,
// fetching a fresh randomness word for every cell; shares are never recombined here.
module skinny_subcells_dom1_sched #(
  parameter int NBYTES   = 16,
  parameter int SBOX_LAT = 2,
  parameter int RW       = 25
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [8*NBYTES-1:0] in_s0,
  input  logic [8*NBYTES-1:0] in_s1,
  output logic                busy,
  output logic                done,
  output logic [8*NBYTES-1:0] out_s0,
  output logic [8*NBYTES-1:0] out_s1,
  input  logic                rnd_valid,
  output logic                rnd_ready,
  input  logic [RW-1:0]       rnd,
  output logic [7:0]          sb_si0,
  output logic [7:0]          sb_si1,
  output logic [RW-1:0]       sb_r,
  input  logic [7:0]          sb_so0,
  input  logic [7:0]          sb_so1,
  output logic [1:0]          fsm_state
);

  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int CW = (SBOX_LAT > 0) ? $clog2(SBOX_LAT + 1) : 1;
  localparam int SW = $clog2(8 * NBYTES);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_EVAL  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]          state;
  logic [8*NBYTES-1:0] st0;
  logic [8*NBYTES-1:0] st1;
  logic [IW-1:0]       idx;
  logic [CW-1:0]       cnt;
  logic [RW-1:0]       r_q;
  logic [SW-1:0]       cell_lsb;
  logic                eval_last;
  logic                last_cell;
  logic                drive_sbox;

  // Cell 0 sits in the most significant byte.
  always_comb begin
    cell_lsb   = SW'(8 * (NBYTES - 1 - int'(idx)));
    eval_last  = (cnt == CW'(SBOX_LAT));
    last_cell  = (idx == IW'(NBYTES - 1));
    drive_sbox = (state == S_FETCH) || (state == S_EVAL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      st0   <= '0;
      st1   <= '0;
      idx   <= '0;
      cnt   <= '0;
      r_q   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            st0   <= in_s0;
            st1   <= in_s1;
            idx   <= '0;
            state <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (rnd_valid) begin
            r_q   <= rnd;
            cnt   <= '0;
            state <= S_EVAL;
          end
        end
        S_EVAL: begin
          cnt <= cnt + CW'(1);
          if (eval_last) begin
            st0[cell_lsb +: 8] <= sb_so0;
            st1[cell_lsb +: 8] <= sb_so1;
            if (last_cell) begin
              state <= S_DONE;
            end else begin
              idx   <= idx + IW'(1);
              state <= S_FETCH;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Handshake: a PRNG word moves on a rising edge where rnd_valid and rnd_ready are both high;
  // rnd_ready is high only in FETCH, and the word stays in r_q untouched until the next FETCH exit.
  always_comb begin
    busy      = (state != S_IDLE);
    done      = (state == S_DONE);
    rnd_ready = (state == S_FETCH);
    sb_si0    = drive_sbox ? st0[cell_lsb +: 8] : 8'h00;
    sb_si1    = drive_sbox ? st1[cell_lsb +: 8] : 8'h00;
    sb_r      = r_q;
    out_s0    = st0;
    out_s1    = st1;
    fsm_state = state;
  end

endmodule
